// File: rtl/mm_cmd_initiator.sv
// Avalon-MM single-transaction master: valid/ready command stream in, response stream out.
// One transaction outstanding at a time; waitrequest honoured; optional timeout for stuck slaves.
module mm_cmd_initiator #(
    parameter int unsigned ADDRESS_SIZE   = 32,
    parameter int unsigned REG_SIZE       = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDRESS_SIZE-1:0] cmd_address,
    input  logic [REG_SIZE-1:0]     cmd_writedata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [REG_SIZE-1:0]     rsp_readdata,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic [ADDRESS_SIZE-1:0] mm_master_address,
    output logic                    mm_master_write,
    output logic [REG_SIZE-1:0]     mm_master_writedata,
    output logic                    mm_master_read,
    input  logic                    mm_master_readdatavalid,
    input  logic [REG_SIZE-1:0]     mm_master_readdata,
    input  logic                    mm_master_waitrequest
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StWr, StRd, StRdWait, StResp} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_hit;

    // The limit is reached on the edge that ends the TIMEOUT_CYCLES-th bus cycle.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
    assign cmd_ready   = (state_q == StIdle);
    assign busy        = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= StIdle;
            cnt_q               <= '0;
            rsp_valid           <= 1'b0;
            rsp_write           <= 1'b0;
            rsp_readdata        <= '0;
            rsp_timeout         <= 1'b0;
            mm_master_address   <= '0;
            mm_master_write     <= 1'b0;
            mm_master_writedata <= '0;
            mm_master_read      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        mm_master_address   <= cmd_address;
                        mm_master_writedata <= cmd_writedata;
                        mm_master_write     <= cmd_write;
                        mm_master_read      <= !cmd_write;
                        cnt_q               <= '0;
                        state_q             <= cmd_write ? StWr : StRd;
                    end
                end
                StWr: begin
                    if (!mm_master_waitrequest || timeout_hit) begin
                        mm_master_write <= 1'b0;
                        rsp_valid       <= 1'b1;
                        rsp_write       <= 1'b1;
                        rsp_readdata    <= '0;
                        rsp_timeout     <= mm_master_waitrequest;
                        state_q         <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRd: begin
                    if (!mm_master_waitrequest) begin
                        mm_master_read <= 1'b0;
                    end
                    // Zero-latency slave: data may arrive in the accept cycle itself.
                    if (!mm_master_waitrequest && mm_master_readdatavalid) begin
                        rsp_valid    <= 1'b1;
                        rsp_write    <= 1'b0;
                        rsp_readdata <= mm_master_readdata;
                        rsp_timeout  <= 1'b0;
                        state_q      <= StResp;
                    end else if (timeout_hit) begin
                        mm_master_read <= 1'b0;
                        rsp_valid      <= 1'b1;
                        rsp_write      <= 1'b0;
                        rsp_readdata   <= '0;
                        rsp_timeout    <= 1'b1;
                        state_q        <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (!mm_master_waitrequest) begin
                            state_q <= StRdWait;
                        end
                    end
                end
                StRdWait: begin
                    if (mm_master_readdatavalid || timeout_hit) begin
                        rsp_valid    <= 1'b1;
                        rsp_write    <= 1'b0;
                        rsp_readdata <= mm_master_readdatavalid ? mm_master_readdata : '0;
                        rsp_timeout  <= !mm_master_readdatavalid;
                        state_q      <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_cmd_initiator.sv
// Self-checking bench for mm_cmd_initiator: directed and random transactions against
// a cycle-count model of bus occupancy, timeout and response contents.
module tb_mm_cmd_initiator;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_address;
    logic [DW-1:0] cmd_writedata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic [DW-1:0] rsp_readdata;
    logic          rsp_timeout;
    logic          busy;
    logic [AW-1:0] mm_master_address;
    logic          mm_master_write;
    logic [DW-1:0] mm_master_writedata;
    logic          mm_master_read;
    logic          mm_master_readdatavalid;
    logic [DW-1:0] mm_master_readdata;
    logic          mm_master_waitrequest;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mm_cmd_initiator #(
        .ADDRESS_SIZE  (AW),
        .REG_SIZE      (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .cmd_valid              (cmd_valid),
        .cmd_ready              (cmd_ready),
        .cmd_write              (cmd_write),
        .cmd_address            (cmd_address),
        .cmd_writedata          (cmd_writedata),
        .rsp_valid              (rsp_valid),
        .rsp_ready              (rsp_ready),
        .rsp_write              (rsp_write),
        .rsp_readdata           (rsp_readdata),
        .rsp_timeout            (rsp_timeout),
        .busy                   (busy),
        .mm_master_address      (mm_master_address),
        .mm_master_write        (mm_master_write),
        .mm_master_writedata    (mm_master_writedata),
        .mm_master_read         (mm_master_read),
        .mm_master_readdatavalid(mm_master_readdatavalid),
        .mm_master_readdata     (mm_master_readdata),
        .mm_master_waitrequest  (mm_master_waitrequest)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_wr"}, 64'(mm_master_write), 64'd0);
        check({tag, "_rd"}, 64'(mm_master_read), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Starts and ends at a negedge with the DUT idle. Slave model: waitrequest for `waits`
    // cycles, read data `lat` cycles after the accept cycle; rsp_ready held low `rdy_delay`.
    task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int waits, input int lat, input int rdy_delay,
                           input logic keep_valid);
        int            natural_len;
        int            total;
        logic          to;
        logic [DW-1:0] exp_rd;
        natural_len = wr ? waits + 1 : waits + lat + 1;
        to          = (natural_len > int'(TO));
        total       = to ? int'(TO) : natural_len;
        exp_rd      = (wr || to) ? '0 : data;

        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        cmd_valid     = 1'b1;
        cmd_write     = wr;
        cmd_address   = addr;
        cmd_writedata = data;
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            if (!keep_valid) cmd_valid = 1'b0;
            check("strobe_wr", 64'(mm_master_write), 64'(wr && (i <= waits)));
            check("strobe_rd", 64'(mm_master_read), 64'(!wr && (i <= waits)));
            check("bus_addr", 64'(mm_master_address), 64'(addr));
            if (wr) check("bus_wdata", 64'(mm_master_writedata), 64'(data));
            check("bus_busy", 64'(busy), 64'd1);
            check("bus_cmd_ready", 64'(cmd_ready), 64'd0);
            mm_master_waitrequest   = (i < waits);
            mm_master_readdatavalid = !wr && (i == waits + lat);
            mm_master_readdata      = mm_master_readdatavalid ? data : DW'($urandom);
        end
        @(negedge clk);
        mm_master_waitrequest   = 1'b0;
        mm_master_readdatavalid = 1'b0;
        for (int j = 0; j <= rdy_delay; j++) begin
            check("rsp_valid", 64'(rsp_valid), 64'd1);
            check("rsp_write", 64'(rsp_write), 64'(wr));
            check("rsp_readdata", 64'(rsp_readdata), 64'(exp_rd));
            check("rsp_timeout", 64'(rsp_timeout), 64'(to));
            check("rsp_cmd_ready", 64'(cmd_ready), 64'd0);
            check("rsp_strobes", 64'({mm_master_write, mm_master_read}), 64'd0);
            if (j == rdy_delay) rsp_ready = 1'b1;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        check("rsp_drop", 64'(rsp_valid), 64'd0);
        check("back_idle", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        rst                     = 1'b1;
        cmd_valid               = 1'b0;
        cmd_write               = 1'b0;
        cmd_address             = '0;
        cmd_writedata           = '0;
        rsp_ready               = 1'b0;
        mm_master_readdatavalid = 1'b0;
        mm_master_readdata      = '0;
        mm_master_waitrequest   = 1'b0;
        repeat (2) @(negedge clk);

        check_quiet("reset");
        check("reset_rsp_fields", 64'({rsp_write, rsp_timeout, rsp_readdata}), 64'd0);
        check("reset_bus_fields", 64'({mm_master_address, mm_master_writedata}), 64'd0);
        rst = 1'b0;

        // Plain write, no waits: strobe at T+1, response at T+2.
        run_txn(1'b1, 32'h4, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);
        // Read with 3 wait cycles, data 2 cycles after accept.
        run_txn(1'b0, 32'h8, 32'h1234_5678, 3, 2, 0, 1'b0);
        // Response back-pressure for 10 cycles.
        run_txn(1'b1, 32'h10, 32'hCAFE_F00D, 1, 0, 10, 1'b0);
        // Zero-latency read slave.
        run_txn(1'b0, 32'h20, 32'hA5A5_5A5A, 0, 0, 0, 1'b0);
        // Completion exactly at the timeout limit wins.
        run_txn(1'b0, 32'h24, 32'h0BAD_F00D, 0, int'(TO) - 1, 0, 1'b0);
        run_txn(1'b1, 32'h28, 32'h1111_2222, int'(TO) - 1, 0, 0, 1'b0);
        // Write stuck in waitrequest times out.
        run_txn(1'b1, 32'h2C, 32'h3333_4444, int'(TO) + 4, 0, 1, 1'b0);
        // Read accepted but no data ever: timeout, then a late readdatavalid is ignored.
        run_txn(1'b0, 32'h30, 32'h5555_6666, 0, 1000, 0, 1'b0);
        mm_master_readdatavalid = 1'b1;
        mm_master_readdata      = 32'h7777_8888;
        @(negedge clk);
        mm_master_readdatavalid = 1'b0;
        check_quiet("late_rdv");
        @(negedge clk);
        check_quiet("late_rdv_after");

        // Back-to-back random commands with cmd_valid held high throughout.
        for (int k = 0; k < 8; k++) begin
            run_txn(1'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b1);
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        check_quiet("b2b_end");

        // Reset while waiting for read data discards the transaction.
        cmd_valid   = 1'b1;
        cmd_write   = 1'b0;
        cmd_address = 32'h40;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rst_case_rd", 64'(mm_master_read), 64'd1);
        @(negedge clk);
        check("rst_case_rdwait_busy", 64'(busy), 64'd1);
        check("rst_case_rdwait_rd", 64'(mm_master_read), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_quiet("mid_rst");
        mm_master_readdatavalid = 1'b1;
        mm_master_readdata      = 32'h9999_AAAA;
        @(negedge clk);
        mm_master_readdatavalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_quiet("mid_rst_after");
            @(negedge clk);
        end

        // Normal operation resumes after the aborted transaction.
        run_txn(1'b0, 32'h44, 32'hBEEF_0001, 1, 1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
